// File: rtl/usb_tx_controller.sv
// USB transmit sequencer: drives SYNC, PID, payload and CRC16 bytes
// into the serializer, then requests EOP and reports done/error.
module usb_tx_controller #(
  parameter int MAX_BYTES      = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = $clog2(MAX_BYTES+1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  input  logic             byte_sent,
  input  logic             eop_done,
  input  logic [15:0]      crc_val,
  output logic             load_byte,
  output logic [7:0]       tx_byte,
  output logic             fifo_read,
  output logic             crc_clr,
  output logic             crc_en,
  output logic             send_eop,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES-1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_SYNC,
    S_TX_SYNC,
    S_LD_PID,
    S_TX_PID,
    S_LD_DATA,
    S_TX_DATA,
    S_LD_CRCL,
    S_TX_CRCL,
    S_LD_CRCH,
    S_TX_CRCH,
    S_EOP,
    S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic start_data;
  logic pid_data;
  logic too_long;
  logic wd_exp;
  logic wd_run;

  assign start_data = (tx_pid == 4'b0011) || (tx_pid == 4'b1011);
  assign pid_data   = (pid_q == 4'b0011) || (pid_q == 4'b1011);
  assign too_long   = int'(tx_len) > MAX_BYTES;
  assign wd_exp     = wd_q >= WD_LIM;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= 4'h0;
      rem_q   <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (start_data && too_long) begin
            err_d = 1'b1;
          end else begin
            pid_d   = tx_pid;
            rem_d   = tx_len;
            state_d = S_LD_SYNC;
          end
        end
      end
      S_LD_SYNC: state_d = S_TX_SYNC;
      S_TX_SYNC: begin
        if (byte_sent)   state_d = S_LD_PID;
        else if (wd_exp) state_d = S_ABORT;
      end
      S_LD_PID: state_d = S_TX_PID;
      S_TX_PID: begin
        if (byte_sent) begin
          if (!pid_data)              state_d = S_EOP;
          else if (rem_q == '0)       state_d = S_LD_CRCL;
          else if (fifo_empty)        state_d = S_ABORT;
          else                        state_d = S_LD_DATA;
        end else if (wd_exp) begin
          state_d = S_ABORT;
        end
      end
      S_LD_DATA: begin
        rem_d   = rem_q - LEN_W'(1);
        state_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (byte_sent) begin
          if (rem_q == '0)     state_d = S_LD_CRCL;
          else if (fifo_empty) state_d = S_ABORT;
          else                 state_d = S_LD_DATA;
        end else if (wd_exp) begin
          state_d = S_ABORT;
        end
      end
      S_LD_CRCL: state_d = S_TX_CRCL;
      S_TX_CRCL: begin
        if (byte_sent)   state_d = S_LD_CRCH;
        else if (wd_exp) state_d = S_ABORT;
      end
      S_LD_CRCH: state_d = S_TX_CRCH;
      S_TX_CRCH: begin
        if (byte_sent)   state_d = S_EOP;
        else if (wd_exp) state_d = S_ABORT;
      end
      S_EOP: begin
        if (eop_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (wd_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (eop_done || wd_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog only runs while waiting on the serializer
  always_comb begin
    wd_run = 1'b0;
    unique case (state_q)
      S_TX_SYNC, S_TX_PID, S_TX_DATA,
      S_TX_CRCL, S_TX_CRCH, S_EOP, S_ABORT: wd_run = 1'b1;
      default: wd_run = 1'b0;
    endcase
    if (!wd_run || state_d != state_q) wd_d = '0;
    else                               wd_d = wd_q + WD_W'(1);
  end

  always_comb begin
    load_byte = 1'b0;
    tx_byte   = 8'h00;
    fifo_read = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    send_eop  = 1'b0;
    unique case (state_q)
      S_LD_SYNC: begin
        load_byte = 1'b1;
        tx_byte   = 8'h80;
      end
      S_LD_PID: begin
        load_byte = 1'b1;
        tx_byte   = {~pid_q, pid_q};
        crc_clr   = 1'b1;
      end
      S_LD_DATA: begin
        load_byte = 1'b1;
        tx_byte   = fifo_rdata;
        fifo_read = 1'b1;
        crc_en    = 1'b1;
      end
      S_LD_CRCL: begin
        load_byte = 1'b1;
        tx_byte   = crc_val[7:0];
      end
      S_LD_CRCH: begin
        load_byte = 1'b1;
        tx_byte   = crc_val[15:8];
      end
      S_EOP, S_ABORT: send_eop = 1'b1;
      default: ;
    endcase
  end

  assign tx_busy  = state_q != S_IDLE;
  assign tx_done  = done_q;
  assign tx_error = err_q;

endmodule

// File: tb/tb_usb_tx_controller.sv
// Directed bench for usb_tx_controller with a simple
// serializer/FIFO responder model.
module tb_usb_tx_controller;

  localparam int MAXB = 64;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        tx_start;
  logic [3:0]  tx_pid;
  logic [6:0]  tx_len;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        byte_sent;
  logic        eop_done;
  logic [15:0] crc_val;
  logic        load_byte;
  logic [7:0]  tx_byte;
  logic        fifo_read;
  logic        crc_clr;
  logic        crc_en;
  logic        send_eop;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_error;

  usb_tx_controller #(
    .MAX_BYTES(MAXB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .tx_start(tx_start),
    .tx_pid(tx_pid),
    .tx_len(tx_len),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .byte_sent(byte_sent),
    .eop_done(eop_done),
    .crc_val(crc_val),
    .load_byte(load_byte),
    .tx_byte(tx_byte),
    .fifo_read(fifo_read),
    .crc_clr(crc_clr),
    .crc_en(crc_en),
    .send_eop(send_eop),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] fifo[$];
  int load_cnt, read_cnt, crcen_cnt, clr_cnt;
  int done_cnt, err_cnt, eop_seen;
  int sent_cnt, eop_cnt, t_sync, t_eop;
  logic ser_on;
  logic [7:0] dummy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer and FIFO responder; samples on the falling edge
  always @(negedge clk) begin
    byte_sent = 1'b0;
    eop_done  = 1'b0;
    if (load_byte) begin
      got.push_back(tx_byte);
      load_cnt++;
      if (load_cnt == 1) t_sync = cyc;
      sent_cnt = 3;
    end else if (sent_cnt > 0) begin
      sent_cnt--;
      if (sent_cnt == 0 && ser_on) byte_sent = 1'b1;
    end
    if (send_eop) begin
      if (eop_seen == 0) t_eop = cyc;
      eop_seen = 1;
      eop_cnt++;
      if (eop_cnt == 3) eop_done = 1'b1;
    end else begin
      eop_cnt = 0;
    end
    if (fifo_read) begin
      read_cnt++;
      if (fifo.size() > 0) dummy = fifo.pop_front();
    end
    if (crc_en)   crcen_cnt++;
    if (crc_clr)  clr_cnt++;
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    fifo_empty = (fifo.size() == 0);
    fifo_rdata = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic clr_stats();
    got.delete();
    exp_q.delete();
    load_cnt = 0; read_cnt = 0; crcen_cnt = 0; clr_cnt = 0;
    done_cnt = 0; err_cnt = 0; eop_seen = 0;
    sent_cnt = 0; eop_cnt = 0; t_sync = 0; t_eop = 0;
  endtask

  task automatic set_fifo();
    fifo_empty = (fifo.size() == 0);
    fifo_rdata = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic start_pkt(input logic [3:0] pid, input logic [6:0] len);
    tx_pid   = pid;
    tx_len   = len;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int n;
    n = 0;
    while (done_cnt + err_cnt == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("end_bound", 32'(n < bound), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_pid   = 4'h0;
    tx_len   = 7'd0;
    crc_val  = 16'h0000;
    byte_sent = 1'b0;
    eop_done  = 1'b0;
    ser_on   = 1'b1;
    fifo     = {};
    set_fifo();
    clr_stats();
    repeat (3) @(negedge clk);

    chk("rst_load",  32'(load_byte), 32'd0);
    chk("rst_byte",  32'(tx_byte),   32'd0);
    chk("rst_busy",  32'(tx_busy),   32'd0);
    chk("rst_eop",   32'(send_eop),  32'd0);
    chk("rst_flags", 32'({fifo_read, crc_clr, crc_en, tx_done, tx_error}), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // ACK handshake, also checks start-to-SYNC latency
    clr_stats();
    start_pkt(4'b0010, 7'd0);
    #1;
    chk("ack_lat_load", 32'(load_byte), 32'd1);
    chk("ack_lat_byte", 32'(tx_byte), 32'h80);
    chk("ack_lat_busy", 32'(tx_busy), 32'd1);
    wait_end(200);
    exp_q = {8'h80, 8'hD2};
    chk_bytes("ack");
    chk("ack_reads", read_cnt, 0);
    chk("ack_crcen", crcen_cnt, 0);
    chk("ack_eop", eop_seen, 1);
    chk("ack_done", done_cnt, 1);
    chk("ack_err", err_cnt, 0);
    chk("ack_busy", 32'(tx_busy), 32'd0);

    // DATA0 with two payload bytes
    clr_stats();
    fifo = {8'hA5, 8'h3C};
    set_fifo();
    crc_val = 16'h1234;
    @(negedge clk);
    start_pkt(4'b0011, 7'd2);
    wait_end(400);
    exp_q = {8'h80, 8'hC3, 8'hA5, 8'h3C, 8'h34, 8'h12};
    chk_bytes("d0");
    chk("d0_clr", clr_cnt, 1);
    chk("d0_reads", read_cnt, 2);
    chk("d0_crcen", crcen_cnt, 2);
    chk("d0_done", done_cnt, 1);
    chk("d0_err", err_cnt, 0);

    // DATA1 with zero-length payload
    clr_stats();
    fifo = {};
    set_fifo();
    crc_val = 16'hBEEF;
    @(negedge clk);
    start_pkt(4'b1011, 7'd0);
    wait_end(400);
    exp_q = {8'h80, 8'h4B, 8'hEF, 8'hBE};
    chk_bytes("d1z");
    chk("d1z_reads", read_cnt, 0);
    chk("d1z_done", done_cnt, 1);

    // FIFO underflow after the first payload byte
    clr_stats();
    fifo = {8'h77};
    set_fifo();
    @(negedge clk);
    start_pkt(4'b0011, 7'd3);
    wait_end(400);
    exp_q = {8'h80, 8'hC3, 8'h77};
    chk_bytes("uf");
    chk("uf_eop", eop_seen, 1);
    chk("uf_err", err_cnt, 1);
    chk("uf_done", done_cnt, 0);

    // byte_sent withheld after SYNC: watchdog abort
    clr_stats();
    ser_on = 1'b0;
    @(negedge clk);
    start_pkt(4'b0010, 7'd0);
    wait_end(TMO + 200);
    ser_on = 1'b1;
    chk("tmo_nbytes", got.size(), 1);
    chk("tmo_err", err_cnt, 1);
    chk("tmo_done", done_cnt, 0);
    chk("tmo_window",
        32'((t_eop - t_sync) >= TMO - 2 && (t_eop - t_sync) <= TMO + 2),
        32'd1);

    // Oversize data packet rejected from IDLE
    clr_stats();
    @(negedge clk);
    start_pkt(4'b0011, 7'(MAXB + 1));
    #1;
    chk("big_err_pulse", 32'(tx_error), 32'd1);
    chk("big_busy", 32'(tx_busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("big_loads", load_cnt, 0);
    chk("big_err", err_cnt, 1);

    // Reset asserted during TX_DATA
    clr_stats();
    fifo = {8'h11, 8'h22};
    set_fifo();
    @(negedge clk);
    start_pkt(4'b0011, 7'd2);
    for (int i = 0; i < 100 && load_cnt < 3; i++) @(negedge clk);
    @(negedge clk);
    chk("mr_reached", load_cnt, 3);
    n_rst = 1'b0;
    #1;
    chk("mr_load", 32'(load_byte), 32'd0);
    chk("mr_busy", 32'(tx_busy), 32'd0);
    chk("mr_outs", 32'({tx_byte, fifo_read, crc_clr, crc_en, send_eop,
                        tx_done, tx_error}), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    fifo = {};
    set_fifo();
    repeat (8) @(negedge clk);
    chk("mr_no_flags", done_cnt + err_cnt, 0);

    clr_stats();
    @(negedge clk);
    start_pkt(4'b0010, 7'd0);
    wait_end(200);
    exp_q = {8'h80, 8'hD2};
    chk_bytes("post");
    chk("post_done", done_cnt, 1);
    chk("post_err", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_controller.md
Name: usb_tx_controller

Overview:
Sequences the USB transmit datapath: serializer/bit-stuffer, CRC16 unit and TX data FIFO. On a start request it emits SYNC, PID, optional payload and CRC16 bytes one at a time to the serializer, then requests EOP. It is the transmit-side counterpart of the RX controller and reports done/error status to the protocol layer. Handshake packets carry PID only; data packets carry PID, payload and CRC.

Parameters:
MAX_BYTES, 64, maximum payload bytes per data packet
TIMEOUT_CYCLES, 1024, cycles allowed for a byte_sent or eop_done response before abort
LEN_W, $clog2(MAX_BYTES+1), width of tx_len

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle start request; ignored unless IDLE
tx_pid  in  4  PID nibble; 4'b0011 (DATA0) / 4'b1011 (DATA1) = data packet, any other value = handshake
tx_len  in  LEN_W  payload byte count, sampled with tx_start
fifo_empty  in  1  TX FIFO empty
fifo_rdata  in  8  FIFO head byte, first-word-fall-through
byte_sent  in  1  serializer pulse: loaded byte fully shifted out
eop_done  in  1  serializer pulse: EOP complete
crc_val  in  16  final (already complemented) CRC16 from CRC unit
load_byte  out  1  tx_byte valid; serializer loads it
tx_byte  out  8  byte to serialize, LSB first on the wire
fifo_read  out  1  pop FIFO head
crc_clr  out  1  clear CRC unit
crc_en  out  1  accumulate tx_byte into CRC
send_eop  out  1  request EOP generation
tx_busy  out  1  high in every non-IDLE state
tx_done  out  1  one-cycle pulse on normal completion
tx_error  out  1  one-cycle pulse on rejected or aborted packet

Behaviour:
- Reset: all outputs 0, tx_byte 8'h00, state IDLE, counters cleared. Asserting n_rst mid-packet aborts immediately with no tx_error or tx_done.
- States: IDLE, LD_SYNC, TX_SYNC, LD_PID, TX_PID, LD_DATA, TX_DATA, LD_CRCL, TX_CRCL, LD_CRCH, TX_CRCH, EOP, ABORT.
- Outputs are a Moore decode of state. Every LD_* state lasts exactly one cycle with load_byte=1.
- IDLE + tx_start: for a data packet with tx_len > MAX_BYTES, pulse tx_error next cycle and stay IDLE. Otherwise latch pid/len, remaining := len, and enter LD_SYNC.
- LD_SYNC: tx_byte=8'h80. LD_PID: tx_byte={~pid,pid}, crc_clr=1. LD_DATA: tx_byte=fifo_rdata, fifo_read=1, crc_en=1, remaining decrements. LD_CRCL: tx_byte=crc_val[7:0]. LD_CRCH: tx_byte=crc_val[15:8].
- Each TX_* state waits for byte_sent, then enters the next state on the following cycle.
  - TX_SYNC -> LD_PID.
  - TX_PID: handshake -> EOP. Data with remaining=0 -> LD_CRCL. Otherwise -> LD_DATA.
  - TX_DATA: remaining>0 -> LD_DATA; else -> LD_CRCL.
  - TX_CRCL -> LD_CRCH. TX_CRCH -> EOP.
- Underflow: on the byte_sent that would move to LD_DATA, if fifo_empty=1, go to ABORT.
- EOP: send_eop=1 held until eop_done. Then IDLE, with a tx_done pulse on the cycle after eop_done.
- ABORT: send_eop=1 until eop_done. Then IDLE, with a tx_error pulse on the cycle after eop_done.
- Watchdog: counter clears on every LD_* state and on state entry, and increments in TX_*, EOP and ABORT.
  - Reaching TIMEOUT_CYCLES in TX_* -> ABORT.
  - Reaching TIMEOUT_CYCLES in EOP or ABORT -> IDLE with a tx_error pulse.
- byte_sent arriving in a non-TX state is ignored. tx_start while busy is ignored.
- Latency: tx_start sampled at edge k -> load_byte with SYNC during cycle k+1.

Test Plan:
- ACK (tx_pid=4'b0010): bytes 8'h80 then 8'hD2, no fifo_read or crc_en, send_eop, then tx_done after eop_done, tx_busy low.
- DATA0, tx_len=2, FIFO {8'hA5,8'h3C}, crc_val=16'h1234: bytes 80,C3,A5,3C,34,12; crc_clr once; exactly two fifo_read/crc_en pulses; tx_done.
- DATA1 with tx_len=0: bytes 80,4B,crc_val[7:0],crc_val[15:8]; no fifo_read; tx_done.
- DATA0, tx_len=3, FIFO holding 1 byte: after the first data byte's byte_sent -> ABORT, send_eop, then tx_error after eop_done; never tx_done.
- byte_sent withheld after SYNC: ABORT at TIMEOUT_CYCLES. Also tx_len=MAX_BYTES+1 -> tx_error with no load_byte.
- n_rst low during TX_DATA: all outputs 0 immediately. A new tx_start after release transmits a clean packet.
